// File: rtl/bus_arbiter_if.sv
// Bus arbitration handshake bundle: per-master request/grant lines plus
// ownership status reported by the arbiter.
interface bus_arbiter_if #(
    parameter int MASTERS = 4
);
    localparam int ID_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    logic [MASTERS-1:0] bus_req;
    logic [MASTERS-1:0] bus_grant;
    logic               bus_busy;
    logic [ID_W-1:0]    grant_id;
    logic               timeout_err;

    // Requester side: raises requests, observes grants.
    modport master (
        output bus_req,
        input  bus_grant,
        input  bus_busy,
        input  grant_id,
        input  timeout_err
    );

    // Arbiter side: samples requests, drives grants and status.
    modport slave (
        input  bus_req,
        output bus_grant,
        output bus_busy,
        output grant_id,
        output timeout_err
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin, non-preemptive system bus arbiter with a mandatory one-cycle
// idle turnaround between owners so tri-state data drivers never overlap.
// Optional ownership limit is enabled by defining BUS_ARBITER_TIMEOUT_EN;
// without it a grant is held for as long as its request stays high and
// timeout_err is tied low.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | no owner, arbitrate every edge
// GRANT      | one master owns the bus until its request drops (or times out)
// TURNAROUND | one forced all-zero grant cycle, then arbitrate again
module bus_arbiter #(
    parameter int MASTERS        = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.slave  bus
);
    localparam int ID_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT      = 2'd1,
        TURNAROUND = 2'd2
    } state_t;

    state_t               state;
    logic [ID_W-1:0]      rr_ptr;

    logic [2*MASTERS-1:0] req_dbl;
    logic [MASTERS-1:0]   req_rot;
    logic                 win_found;
    logic [ID_W:0]        win_ofs;
    logic [ID_W:0]        win_sum;
    logic [ID_W-1:0]      win_idx;
    logic [ID_W:0]        nxt_sum;
    logic [ID_W-1:0]      next_ptr;
    logic                 owner_req;

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]     hold_cnt;
    logic                 timeout_hit;
    assign timeout_hit = (hold_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign bus.timeout_err = 1'b0;
`endif

    // Grant is one-hot, so the owner's request is simply req masked by grant.
    assign owner_req = |(bus.bus_req & bus.bus_grant);

    // Rotate requests so rr_ptr sits at bit 0; lowest set bit is the winner.
    always_comb begin
        req_dbl   = {bus.bus_req, bus.bus_req};
        req_rot   = MASTERS'(req_dbl >> rr_ptr);
        win_found = 1'b0;
        win_ofs   = '0;
        for (int i = MASTERS - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_found = 1'b1;
                win_ofs   = (ID_W + 1)'(i);
            end
        end
        win_sum = {1'b0, rr_ptr} + win_ofs;
        if (win_sum >= (ID_W + 1)'(MASTERS)) begin
            win_sum = win_sum - (ID_W + 1)'(MASTERS);
        end
        win_idx = ID_W'(win_sum);
    end

    // Pointer value used after the current owner releases: owner + 1, wrapped.
    always_comb begin
        nxt_sum = {1'b0, bus.grant_id} + (ID_W + 1)'(1);
        if (nxt_sum >= (ID_W + 1)'(MASTERS)) begin
            nxt_sum = nxt_sum - (ID_W + 1)'(MASTERS);
        end
        next_ptr = ID_W'(nxt_sum);
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            bus.bus_grant <= '0;
            bus.bus_busy  <= 1'b0;
            bus.grant_id  <= '0;
`ifdef BUS_ARBITER_TIMEOUT_EN
            hold_cnt        <= '0;
            bus.timeout_err <= 1'b0;
`endif
        end else begin
`ifdef BUS_ARBITER_TIMEOUT_EN
            bus.timeout_err <= 1'b0;
`endif
            case (state)
                IDLE, TURNAROUND: begin
                    if (win_found) begin
                        bus.bus_grant <= MASTERS'(1) << win_idx;
                        bus.bus_busy  <= 1'b1;
                        bus.grant_id  <= win_idx;
                        state         <= GRANT;
`ifdef BUS_ARBITER_TIMEOUT_EN
                        hold_cnt      <= '0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        bus.bus_grant <= '0;
                        bus.bus_busy  <= 1'b0;
                        rr_ptr        <= next_ptr;
                        state         <= TURNAROUND;
`ifdef BUS_ARBITER_TIMEOUT_EN
                    end else if (timeout_hit) begin
                        bus.bus_grant   <= '0;
                        bus.bus_busy    <= 1'b0;
                        rr_ptr          <= next_ptr;
                        bus.timeout_err <= 1'b1;
                        state           <= TURNAROUND;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
`endif
                    end
                end
                default: begin
                    bus.bus_grant <= '0;
                    bus.bus_busy  <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, randomized run
// against a rule-level reference model, single-master and timeout corners.
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    bus_arbiter_if #(.MASTERS(4)) ifc  ();
    bus_arbiter_if #(.MASTERS(1)) ifc1 ();
    bus_arbiter_if #(.MASTERS(4)) ifct ();

    bus_arbiter #(.MASTERS(4), .TIMEOUT_CYCLES(256)) dut (
        .clk (clk), .rst (rst), .bus (ifc.slave)
    );
    bus_arbiter #(.MASTERS(1), .TIMEOUT_CYCLES(256)) dut1 (
        .clk (clk), .rst (rst), .bus (ifc1.slave)
    );
    bus_arbiter #(.MASTERS(4), .TIMEOUT_CYCLES(8)) dutt (
        .clk (clk), .rst (rst), .bus (ifct.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] grant;
        logic       busy;
        logic [1:0] id;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(logic r, logic [3:0] q, logic [3:0] g, logic b, logic [1:0] id);
        vec_t v;
        v.rst = r; v.req = q; v.grant = g; v.busy = b; v.id = id;
        vecs.push_back(v);
    endfunction

    // Reference model: owner index (-1 none), scan pointer, last owner.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_last  = 0;

    function automatic void model_step(logic r, logic [3:0] q);
        if (r) begin
            m_owner = -1; m_ptr = 0; m_last = 0;
        end else if (m_owner >= 0) begin
            if (!q[m_owner]) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (q[c]) begin
                    m_owner = c;
                    m_last  = c;
                    break;
                end
            end
        end
    endfunction

    initial begin
        ifc.bus_req  = '0;
        ifc1.bus_req = '0;
        ifct.bus_req = '0;

        // Reset, single request, reset while granted.
        add(1, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0100, 4'b0100, 1, 2);
        add(0, 4'b0100, 4'b0100, 1, 2);
        add(1, 4'b0100, 4'b0000, 0, 0);
        add(0, 4'b0000, 4'b0000, 0, 0);
        // Round robin with all requesting, owner drops for one cycle.
        add(0, 4'b1111, 4'b0001, 1, 0);
        add(0, 4'b1111, 4'b0001, 1, 0);
        add(0, 4'b1111, 4'b0001, 1, 0);
        add(0, 4'b1110, 4'b0000, 0, 0);
        add(0, 4'b1111, 4'b0010, 1, 1);
        add(0, 4'b1111, 4'b0010, 1, 1);
        add(0, 4'b1111, 4'b0010, 1, 1);
        add(0, 4'b1101, 4'b0000, 0, 1);
        add(0, 4'b1111, 4'b0100, 1, 2);
        add(0, 4'b1111, 4'b0100, 1, 2);
        add(0, 4'b1111, 4'b0100, 1, 2);
        add(0, 4'b1011, 4'b0000, 0, 2);
        add(0, 4'b1111, 4'b1000, 1, 3);
        add(0, 4'b1111, 4'b1000, 1, 3);
        add(0, 4'b1111, 4'b1000, 1, 3);
        add(0, 4'b0111, 4'b0000, 0, 3);
        add(0, 4'b1111, 4'b0001, 1, 0);
        add(0, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0000, 4'b0000, 0, 0);
        // No preemption: owner 1 holds, master 3 waits behind one gap.
        add(1, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0010, 4'b0010, 1, 1);
        add(0, 4'b1010, 4'b0010, 1, 1);
        add(0, 4'b1010, 4'b0010, 1, 1);
        add(0, 4'b1000, 4'b0000, 0, 1);
        add(0, 4'b1000, 4'b1000, 1, 3);
        add(0, 4'b0000, 4'b0000, 0, 3);
        // One-cycle pulse from master 0 while master 2 owns: never granted.
        add(0, 4'b0100, 4'b0100, 1, 2);
        add(0, 4'b0101, 4'b0100, 1, 2);
        add(0, 4'b0100, 4'b0100, 1, 2);
        add(0, 4'b0000, 4'b0000, 0, 2);
        add(0, 4'b0000, 4'b0000, 0, 2);
        add(0, 4'b0000, 4'b0000, 0, 2);
        // Previous owner alone re-requesting is re-granted after the gap.
        add(0, 4'b0001, 4'b0001, 1, 0);
        add(0, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0001, 4'b0001, 1, 0);
        add(0, 4'b0000, 4'b0000, 0, 0);

        foreach (vecs[i]) begin
            rst         = vecs[i].rst;
            ifc.bus_req = vecs[i].req;
            step();
            check($sformatf("vec%0d_grant", i), int'(ifc.bus_grant), int'(vecs[i].grant));
            check($sformatf("vec%0d_busy", i),  int'(ifc.bus_busy),  int'(vecs[i].busy));
            check($sformatf("vec%0d_id", i),    int'(ifc.grant_id),  int'(vecs[i].id));
        end

        // Randomized traffic against the reference model.
        rst = 1'b1; ifc.bus_req = '0;
        model_step(1'b1, 4'b0000);
        step();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic       r;
            logic [3:0] q;
            logic [3:0] eg;
            r = ($urandom_range(0, 99) == 0);
            q = 4'($urandom_range(0, 15));
            if (m_owner >= 0 && $urandom_range(0, 7) != 0) q[m_owner] = 1'b1;
            rst = r;
            ifc.bus_req = q;
            model_step(r, q);
            step();
            eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
            check("rand_grant", int'(ifc.bus_grant), int'(eg));
            check("rand_busy",  int'(ifc.bus_busy),  (m_owner >= 0) ? 1 : 0);
            check("rand_id",    int'(ifc.grant_id),  m_last);
            check("rand_onehot", int'($countones(ifc.bus_grant) <= 1), 1);
        end
        rst = 1'b0; ifc.bus_req = '0;

        // Single master: hold indefinitely, drop, re-raise.
        rst = 1'b1; step(); rst = 1'b0;
        ifc1.bus_req = 1'b1;
        step();
        check("m1_first_grant", int'(ifc1.bus_grant), 1);
        for (int k = 0; k < 20; k++) begin
            step();
            check("m1_hold", int'(ifc1.bus_grant), 1);
        end
        ifc1.bus_req = 1'b0;
        step();
        check("m1_drop", int'(ifc1.bus_grant), 0);
        check("m1_drop_busy", int'(ifc1.bus_busy), 0);
        ifc1.bus_req = 1'b1;
        step();
        check("m1_regrant", int'(ifc1.bus_grant), 1);
        check("m1_id", int'(ifc1.grant_id), 0);
        ifc1.bus_req = 1'b0;
        step();

        // Ownership limit of 8 cycles on the dedicated instance.
        rst = 1'b1; step(); rst = 1'b0;
        ifct.bus_req = 4'b0010;
`ifdef BUS_ARBITER_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            step();
            check("to_hold_grant", int'(ifct.bus_grant), 2);
            check("to_hold_err", int'(ifct.timeout_err), 0);
        end
        step();
        check("to_revoke_grant", int'(ifct.bus_grant), 0);
        check("to_revoke_err", int'(ifct.timeout_err), 1);
        step();
        check("to_regrant_1", int'(ifct.bus_grant), 2);
        check("to_err_pulse_end", int'(ifct.timeout_err), 0);
        ifct.bus_req = 4'b0110;
        for (int k = 0; k < 7; k++) begin
            step();
            check("to_hold2_grant", int'(ifct.bus_grant), 2);
        end
        step();
        check("to_revoke2_grant", int'(ifct.bus_grant), 0);
        check("to_revoke2_err", int'(ifct.timeout_err), 1);
        step();
        check("to_regrant_2", int'(ifct.bus_grant), 4);
        check("to_regrant_2_id", int'(ifct.grant_id), 2);
`else
        for (int k = 0; k < 20; k++) begin
            step();
            check("nto_hold_grant", int'(ifct.bus_grant), 2);
            check("nto_err", int'(ifct.timeout_err), 0);
        end
`endif
        ifct.bus_req = '0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
